// File: rtl/peak_window_scheduler.sv
// Time-of-day clock (24h internal, 12h BCD display) with programmable peak-hour
// windows, mode override and registered peak flag with edge pulses.
module peak_window_scheduler #(
    parameter int NUM_WIN = 3,
    parameter int IDX_W   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             set_en,
    input  logic [4:0]       set_hr,
    input  logic [5:0]       set_min,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [4:0]       cfg_start,
    input  logic [4:0]       cfg_end,
    input  logic [1:0]       mode,
    output logic [7:0]       hours,
    output logic [7:0]       minutes,
    output logic             pm,
    output logic             peak,
    output logic [IDX_W-1:0] peak_win,
    output logic             peak_rise,
    output logic             peak_fall,
    output logic             err
);

    // Binary (0-59) to two-digit packed BCD.
    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [3:0] tens;
        logic [5:0] rem;
        tens = 4'd0;
        rem  = v;
        if (rem >= 6'd50) begin
            tens = 4'd5;
            rem  = rem - 6'd50;
        end else if (rem >= 6'd40) begin
            tens = 4'd4;
            rem  = rem - 6'd40;
        end else if (rem >= 6'd30) begin
            tens = 4'd3;
            rem  = rem - 6'd30;
        end else if (rem >= 6'd20) begin
            tens = 4'd2;
            rem  = rem - 6'd20;
        end else if (rem >= 6'd10) begin
            tens = 4'd1;
            rem  = rem - 6'd10;
        end
        return {tens, 4'(rem)};
    endfunction

    logic [4:0]       hr_reg, hr_next;
    logic [5:0]       min_reg, min_next;
    logic             err_reg, err_next;
    logic             peak_reg, peak_next;
    logic [IDX_W-1:0] peak_win_reg, peak_win_next;
    logic             peak_rise_reg, peak_fall_reg;
    logic             first_reg;
    logic             set_ok, cfg_ok;
    logic [4:0]       hr12;
    logic [NUM_WIN-1:0] win_active;
    logic [IDX_W-1:0] low_idx;
    logic             auto_peak;

    assign set_ok = set_en && (set_hr <= 5'd23) && (set_min <= 6'd59);
    assign cfg_ok = cfg_we && ({1'b0, cfg_idx} < (IDX_W+1)'(NUM_WIN))
                    && (cfg_start <= 5'd23) && (cfg_end <= 5'd23);

    // A load request always consumes the cycle, even when rejected.
    always_comb begin
        hr_next  = hr_reg;
        min_next = min_reg;
        if (set_en) begin
            if (set_ok) begin
                hr_next  = set_hr;
                min_next = set_min;
            end
        end else if (tick) begin
            if (min_reg == 6'd59) begin
                min_next = 6'd0;
                hr_next  = (hr_reg == 5'd23) ? 5'd0 : hr_reg + 5'd1;
            end else begin
                min_next = min_reg + 6'd1;
            end
        end
        err_next = (set_en && !set_ok) || (cfg_we && !cfg_ok);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hr_reg  <= 5'd0;
            min_reg <= 6'd0;
            err_reg <= 1'b0;
        end else begin
            hr_reg  <= hr_next;
            min_reg <= min_next;
            err_reg <= err_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WIN; gi++) begin : g_win
            localparam logic [4:0] RST_START = (gi == 0) ? 5'd7  :
                                               (gi == 1) ? 5'd12 :
                                               (gi == 2) ? 5'd17 : 5'd0;
            localparam logic [4:0] RST_END   = (gi == 0) ? 5'd10 :
                                               (gi == 1) ? 5'd15 :
                                               (gi == 2) ? 5'd20 : 5'd0;
            logic [4:0] start_reg;
            logic [4:0] end_reg;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    start_reg <= RST_START;
                    end_reg   <= RST_END;
                end else if (cfg_ok && (cfg_idx == IDX_W'(gi))) begin
                    start_reg <= cfg_start;
                    end_reg   <= cfg_end;
                end
            end

            // start > end wraps through midnight; start == end disables.
            assign win_active[gi] =
                (start_reg < end_reg) ? ((hr_reg >= start_reg) && (hr_reg < end_reg)) :
                (start_reg > end_reg) ? ((hr_reg >= start_reg) || (hr_reg < end_reg)) :
                1'b0;
        end
    endgenerate

    always_comb begin
        auto_peak = |win_active;
        low_idx   = '0;
        for (int i = NUM_WIN - 1; i >= 0; i--) begin
            if (win_active[i]) begin
                low_idx = IDX_W'(i);
            end
        end
        peak_next     = auto_peak;
        peak_win_next = low_idx;
        case (mode)
            2'b01: begin
                peak_next     = 1'b0;
                peak_win_next = '0;
            end
            2'b10: begin
                peak_next     = 1'b1;
                peak_win_next = '0;
            end
            default: ;
        endcase
    end

    // first_reg masks edge detection on the first edge out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            peak_reg      <= 1'b0;
            peak_win_reg  <= '0;
            peak_rise_reg <= 1'b0;
            peak_fall_reg <= 1'b0;
            first_reg     <= 1'b1;
        end else begin
            peak_reg      <= peak_next;
            peak_win_reg  <= peak_win_next;
            peak_rise_reg <= !first_reg && peak_next && !peak_reg;
            peak_fall_reg <= !first_reg && !peak_next && peak_reg;
            first_reg     <= 1'b0;
        end
    end

    always_comb begin
        if (hr_reg == 5'd0) begin
            hr12 = 5'd12;
        end else if (hr_reg <= 5'd12) begin
            hr12 = hr_reg;
        end else begin
            hr12 = hr_reg - 5'd12;
        end
    end

    assign hours     = to_bcd({1'b0, hr12});
    assign minutes   = to_bcd(min_reg);
    assign pm        = (hr_reg >= 5'd12);
    assign peak      = peak_reg;
    assign peak_win  = peak_win_reg;
    assign peak_rise = peak_rise_reg;
    assign peak_fall = peak_fall_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_peak_window_scheduler.sv
// Directed-vector bench for peak_window_scheduler; inputs change and outputs
// are sampled 1ns after each rising edge.
module tb_peak_window_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic       set_en;
    logic [4:0] set_hr;
    logic [5:0] set_min;
    logic       cfg_we;
    logic [1:0] cfg_idx;
    logic [4:0] cfg_start;
    logic [4:0] cfg_end;
    logic [1:0] mode;
    logic [7:0] hours;
    logic [7:0] minutes;
    logic       pm;
    logic       peak;
    logic [1:0] peak_win;
    logic       peak_rise;
    logic       peak_fall;
    logic       err;

    int vectors = 0;
    int miscompares = 0;

    peak_window_scheduler #(.NUM_WIN(3), .IDX_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .set_en(set_en),
        .set_hr(set_hr), .set_min(set_min), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_start(cfg_start), .cfg_end(cfg_end), .mode(mode),
        .hours(hours), .minutes(minutes), .pm(pm), .peak(peak),
        .peak_win(peak_win), .peak_rise(peak_rise), .peak_fall(peak_fall), .err(err)
    );

    always #5 clk = ~clk;

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic set_time(input logic [4:0] h, input logic [5:0] m);
        set_en = 1'b1; set_hr = h; set_min = m;
        clk1();
        set_en = 1'b0;
        $display("set %0d:%0d -> hours %h minutes %h pm %0b", h, m, hours, minutes, pm);
    endtask

    task automatic do_tick();
        tick = 1'b1;
        clk1();
        tick = 1'b0;
        $display("tick -> hours %h minutes %h pm %0b", hours, minutes, pm);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mode = 2'b10;
        clk1(); clk1();
        vectors++; if (hours !== 8'h12) begin miscompares++; $display("FAIL rst_hours got %h want 12", hours); end
        vectors++; if (minutes !== 8'h00) begin miscompares++; $display("FAIL rst_minutes got %h want 00", minutes); end
        vectors++; if (pm !== 1'b0) begin miscompares++; $display("FAIL rst_pm got %b want 0", pm); end
        vectors++; if ({peak, peak_win, peak_rise, peak_fall, err} !== 6'b0) begin
            miscompares++; $display("FAIL rst_flags got %b want 000000", {peak, peak_win, peak_rise, peak_fall, err}); end
        rst_n = 1'b1;
        clk1();
        $display("reset released, forced peak -> peak %0b rise %0b", peak, peak_rise);
        vectors++; if (peak !== 1'b1) begin miscompares++; $display("FAIL rel_peak got %b want 1", peak); end
        vectors++; if (peak_rise !== 1'b0) begin miscompares++; $display("FAIL rel_no_rise got %b want 0", peak_rise); end
        mode = 2'b00;
        clk1(); clk1();
    endtask

    task automatic test_rollover_0659();
        set_time(5'd6, 6'd59);
        do_tick();
        vectors++; if (hours !== 8'h07) begin miscompares++; $display("FAIL r0700_hours got %h want 07", hours); end
        vectors++; if (minutes !== 8'h00) begin miscompares++; $display("FAIL r0700_min got %h want 00", minutes); end
        vectors++; if (pm !== 1'b0) begin miscompares++; $display("FAIL r0700_pm got %b want 0", pm); end
        vectors++; if (peak !== 1'b0) begin miscompares++; $display("FAIL r0700_latency got %b want 0", peak); end
        clk1();
        vectors++; if ({peak, peak_win, peak_rise} !== 4'b1001) begin
            miscompares++; $display("FAIL r0700_peak got %b want 1001", {peak, peak_win, peak_rise}); end
        clk1();
        vectors++; if (peak_rise !== 1'b0) begin miscompares++; $display("FAIL r0700_rise_width got %b want 0", peak_rise); end
    endtask

    task automatic test_midnight();
        set_time(5'd23, 6'd59);
        clk1();
        do_tick();
        vectors++; if ({hours, minutes, pm} !== {8'h12, 8'h00, 1'b0}) begin
            miscompares++; $display("FAIL midnight got %h:%h pm %b want 12:00 pm 0", hours, minutes, pm); end
        set_time(5'd12, 6'd0);
        vectors++; if ({hours, pm} !== {8'h12, 1'b1}) begin
            miscompares++; $display("FAIL noon got %h pm %b want 12 pm 1", hours, pm); end
        clk1();
        vectors++; if ({peak, peak_win} !== 3'b101) begin
            miscompares++; $display("FAIL noon_peak got %b want 101", {peak, peak_win}); end
        set_time(5'd21, 6'd7);
        vectors++; if ({hours, minutes, pm} !== {8'h09, 8'h07, 1'b1}) begin
            miscompares++; $display("FAIL t2107 got %h:%h pm %b want 09:07 pm 1", hours, minutes, pm); end
        set_time(5'd10, 6'd59);
        do_tick();
        vectors++; if ({hours, minutes, pm} !== {8'h11, 8'h00, 1'b0}) begin
            miscompares++; $display("FAIL t1100 got %h:%h pm %b want 11:00 pm 0", hours, minutes, pm); end
    endtask

    task automatic test_wrap_window();
        cfg_we = 1'b1; cfg_idx = 2'd1; cfg_start = 5'd22; cfg_end = 5'd2;
        clk1();
        cfg_we = 1'b0;
        $display("cfg idx1 22..2");
        set_time(5'd1, 6'd30);
        vectors++; if ({hours, minutes} !== {8'h01, 8'h30}) begin
            miscompares++; $display("FAIL t0130 got %h:%h want 01:30", hours, minutes); end
        clk1();
        vectors++; if ({peak, peak_win} !== 3'b101) begin
            miscompares++; $display("FAIL wrap_peak got %b want 101", {peak, peak_win}); end
        set_time(5'd2, 6'd0);
        clk1();
        vectors++; if ({peak, peak_fall} !== 2'b01) begin
            miscompares++; $display("FAIL wrap_end got %b want 01", {peak, peak_fall}); end
    endtask

    task automatic test_errors();
        cfg_we = 1'b1; cfg_idx = 2'd3; cfg_start = 5'd1; cfg_end = 5'd5;
        clk1();
        cfg_we = 1'b0;
        $display("cfg idx3 -> err %0b", err);
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL err_idx got %b want 1", err); end
        clk1();
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL err_width got %b want 0", err); end
        cfg_we = 1'b1; cfg_idx = 2'd0; cfg_start = 5'd24; cfg_end = 5'd3;
        clk1();
        cfg_we = 1'b0;
        $display("cfg idx0 start 24 -> err %0b", err);
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL err_hour got %b want 1", err); end
        set_time(5'd5, 6'd60);
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL err_min got %b want 1", err); end
        vectors++; if ({hours, minutes} !== {8'h02, 8'h00}) begin
            miscompares++; $display("FAIL err_time got %h:%h want 02:00", hours, minutes); end
    endtask

    task automatic test_mode();
        set_time(5'd8, 6'd15);
        clk1();
        vectors++; if ({peak, peak_win, peak_rise} !== 4'b1001) begin
            miscompares++; $display("FAIL t0815_auto got %b want 1001", {peak, peak_win, peak_rise}); end
        mode = 2'b01;
        clk1();
        $display("mode 01 -> peak %0b fall %0b", peak, peak_fall);
        vectors++; if ({peak, peak_fall} !== 2'b01) begin
            miscompares++; $display("FAIL force_off got %b want 01", {peak, peak_fall}); end
        mode = 2'b10;
        clk1();
        $display("mode 10 -> peak %0b rise %0b", peak, peak_rise);
        vectors++; if ({peak, peak_rise, peak_win} !== 4'b1100) begin
            miscompares++; $display("FAIL force_on got %b want 1100", {peak, peak_rise, peak_win}); end
        mode = 2'b00;
        clk1();
    endtask

    task automatic test_back_to_back();
        tick = 1'b1;
        set_time(5'd9, 6'd45);
        tick = 1'b0;
        vectors++; if ({hours, minutes} !== {8'h09, 8'h45}) begin
            miscompares++; $display("FAIL set_wins got %h:%h want 09:45", hours, minutes); end
        cfg_we = 1'b1; cfg_idx = 2'd2; cfg_start = 5'd9; cfg_end = 5'd12;
        do_tick();
        cfg_idx = 2'd0; cfg_start = 5'd0; cfg_end = 5'd0;
        do_tick();
        cfg_we = 1'b0;
        vectors++; if ({minutes, peak_win} !== {8'h47, 2'd0}) begin
            miscompares++; $display("FAIL cfg_tick got %h win %0d want 47 win 0", minutes, peak_win); end
        clk1();
        vectors++; if ({peak, peak_win} !== 3'b110) begin
            miscompares++; $display("FAIL cfg_latency got %b want 110", {peak, peak_win}); end
    endtask

    initial begin
        rst_n = 1'b0; tick = 1'b0; set_en = 1'b0; set_hr = '0; set_min = '0;
        cfg_we = 1'b0; cfg_idx = '0; cfg_start = '0; cfg_end = '0; mode = 2'b00;
        #1;
        test_reset();
        test_rollover_0659();
        test_midnight();
        test_wrap_window();
        test_errors();
        test_mode();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/peak_window_scheduler.md
PEAK_WINDOW_SCHEDULER -- requirements
Module: peak_window_scheduler

Interface
REQ-001 Parameter NUM_WIN, default 3; number of programmable peak windows, legal range 1..8.
REQ-002 Parameter IDX_W, default 2; index width, SHALL equal max(1, clog2(NUM_WIN)).
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  reset, synchronous and active-low.
REQ-005 tick  in  1  one-minute strobe, one cycle wide.
REQ-006 set_en  in  1  load time-of-day.
REQ-007 set_hr  in  5  load hour, binary 24h (0-23); set_min  in  6  load minute, binary (0-59).
REQ-008 cfg_we  in  1  window write strobe; cfg_idx  in  IDX_W  window number.
REQ-009 cfg_start  in  5  window start hour (24h, inclusive); cfg_end  in  5  window end hour (24h, exclusive).
REQ-010 mode  in  2  00 auto, 01 force off-peak, 10 force peak, 11 treated as 00.
REQ-011 hours  out  8  12h BCD hour (0x01-0x12); minutes  out  8  BCD minute (0x00-0x59); pm  out  1  PM flag.
REQ-012 peak  out  1  registered peak flag; peak_win  out  IDX_W  lowest active window index.
REQ-013 peak_rise, peak_fall  out  1 each  one-cycle edge pulses; err  out  1  one-cycle rejected-request pulse.

Function
REQ-014 Time SHALL be held internally as hr24 (0-23) and min (0-59) registers.
REQ-015 tick with set_en low: min+1; min 59 -> 0 with hr24+1; 23:59 -> 00:00.
REQ-016 set_en SHALL take priority over tick in the same cycle; the tick is dropped.
REQ-017 set_en with set_hr>23 or set_min>59: time unchanged, err pulses next cycle.
REQ-018 hours/pm SHALL be decoded from hr24: 0 -> 0x12/am; 1-11 -> BCD/am; 12 -> 0x12/pm; 13-23 -> BCD(hr24-12)/pm.
REQ-019 minutes SHALL be BCD of min; hours, minutes, pm reflect the time registers with no added latency.
REQ-020 Window i active: start<end -> start<=hr24<end; start>end (midnight wrap) -> hr24>=start or hr24<end; start==end -> disabled.
REQ-021 cfg_we with cfg_idx<NUM_WIN and both hours<=23 SHALL write the window on that edge.
REQ-022 cfg_we with cfg_idx>=NUM_WIN or either hour >23: no write, err pulses next cycle.
REQ-023 cfg_we and tick/set_en in the same cycle SHALL both take effect.
REQ-024 auto_peak = OR of active windows; mode 01 forces 0, mode 10 forces 1.
REQ-025 peak and peak_win SHALL register from the post-update time/config: tick at edge N -> time visible after N -> peak visible after N+1.
REQ-026 peak_win SHALL be the lowest active index in auto mode, else 0; 0 when no window active.
REQ-027 peak_rise SHALL pulse one cycle when peak goes 0->1; peak_fall when 1->0; both cover mode-forced changes.
REQ-028 Window or mode change without a tick SHALL update peak with the same one-cycle latency.

Reset
REQ-029 rst_n low at an edge: hr24=0, min=0, peak=0, peak_win=0, peak_rise=0, peak_fall=0, err=0.
REQ-030 Reset windows: idx0 = 7..10, idx1 = 12..15, idx2 = 17..20 where NUM_WIN permits; higher indices start=end=0.
REQ-031 Reset mid-operation SHALL discard pending pulses; the first cycle after release generates no peak_rise or peak_fall.

Verification
REQ-032 Reset, then set 06:59 and tick -> hours 0x07, pm 0, minutes 0x00; next cycle peak 1, peak_win 0, peak_rise 1 for one cycle.
REQ-033 Set 23:59, tick -> hours 0x12, pm 0, minutes 0x00; set 12:00 -> hours 0x12, pm 1, peak 1, peak_win 1.
REQ-034 Write idx1 start 22 end 2; set 01:30 -> peak 1, peak_win 1; set 02:00 -> peak 0, peak_fall 1.
REQ-035 cfg_idx 3 with NUM_WIN=3, or cfg_start 24 -> err 1 one cycle, windows unchanged; set_min 60 -> err 1, time unchanged.
REQ-036 At 08:15 in auto, mode 01 -> peak 0 and peak_fall; mode 10 -> peak 1 and peak_rise; set_en and tick together -> loaded time wins.
